// File: rtl/bridge_pkg.sv
// Shared state encoding, device address map and window decode for the
// processor-port arbiter in front of the Bridge.
package bridge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } brState_t;

   localparam logic [27:0] DEV0_BASE      = 28'h0000_7F0;
   localparam logic [27:0] DEV1_BASE      = 28'h0000_7F1;
   localparam logic [3:0]  WIN_LIMIT      = 4'hB;
   localparam logic [31:0] DEBUG_DEV_DATA = 32'hABCD_FFFF;

   // Only the first 12 bytes of each 16-byte device block are registers.
   function automatic logic isDevHit(input logic [31:0] addr);
      logic inBlock;
      inBlock = (addr[31:4] == DEV0_BASE) || (addr[31:4] == DEV1_BASE);
      return inBlock && (addr[3:0] <= WIN_LIMIT);
   endfunction

endpackage

// File: rtl/bridge_rr_arb.sv
// Two-master arbiter: round-robin on ties or fixed M0 priority, with the
// last-grant pointer updated only when the owner accepts a grant.
module bridge_rr_arb
   import bridge_pkg::*;
#(
   parameter bit RR_EN = 1'b1
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] gnt
);

   logic lastGntR;

   // Winner selection; a tie goes to the master not granted last.
   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11) begin
         if (RR_EN && !lastGntR) begin
            gnt = 2'b10;
         end else begin
            gnt = 2'b01;
         end
      end else begin
         gnt = req;
      end
   end

   // Last-grant pointer; starts at M1 so M0 wins the first tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lastGntR <= 1'b1;
      end else if (update && (gnt != 2'b00)) begin
         lastGntR <= gnt[1];
      end else begin
         lastGntR <= lastGntR;
      end
   end

endmodule

// File: rtl/bridge_arbiter.sv
// Shares the Bridge processor port between M0 (CPU) and M1 (debug/DMA):
// grant, latch, ACC_CYC access cycles, then a one-cycle ack with read data.
module bridge_arbiter
   import bridge_pkg::*;
#(
   parameter bit          RR_EN   = 1'b1,
   parameter int unsigned ACC_CYC = 1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wd,
   input  logic        m0_we,
   output logic        m0_ack,
   output logic [31:0] m0_rd,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wd,
   input  logic        m1_we,
   output logic        m1_ack,
   output logic [31:0] m1_rd,
   output logic        m1_err,
   output logic [31:0] pr_addr,
   output logic [31:0] pr_wd,
   output logic        pr_we,
   input  logic [31:0] pr_rd
);

   localparam logic [3:0] CNT_LOAD = 4'(ACC_CYC - 1);

   brState_t    stateR;
   logic [31:0] addrR;
   logic [31:0] wdR;
   logic        weR;
   logic        hitR;
   logic        winR;
   logic [3:0]  cntR;
   logic [1:0]  gntS;
   logic [31:0] selAddrS;
   logic [31:0] selWdS;
   logic        selWeS;
   logic        selHitS;
   logic [31:0] capRdS;

   bridge_rr_arb #(.RR_EN(RR_EN)) uArb (
      .clk    (clk),
      .reset  (reset),
      .req    ({m1_req, m0_req}),
      .update (stateR == IDLE),
      .gnt    (gntS)
   );

   // Request fields of whichever master the arbiter picked.
   always_comb begin
      selAddrS = m0_addr;
      selWdS   = m0_wd;
      selWeS   = m0_we;
      if (gntS[1]) begin
         selAddrS = m1_addr;
         selWdS   = m1_wd;
         selWeS   = m1_we;
      end else begin
         selAddrS = m0_addr;
         selWdS   = m0_wd;
         selWeS   = m0_we;
      end
      selHitS = isDevHit(selAddrS);
      capRdS  = weR ? 32'h0000_0000 : pr_rd;
   end

   // Transaction sequencer; every output is a register cleared outside RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateR <= IDLE;
         addrR  <= 32'h0000_0000;
         wdR    <= 32'h0000_0000;
         weR    <= 1'b0;
         hitR   <= 1'b0;
         winR   <= 1'b0;
         cntR   <= 4'd0;
         pr_we  <= 1'b0;
         m0_ack <= 1'b0;
         m0_rd  <= 32'h0000_0000;
         m0_err <= 1'b0;
         m1_ack <= 1'b0;
         m1_rd  <= 32'h0000_0000;
         m1_err <= 1'b0;
      end else begin
         pr_we  <= 1'b0;
         m0_ack <= 1'b0;
         m0_rd  <= 32'h0000_0000;
         m0_err <= 1'b0;
         m1_ack <= 1'b0;
         m1_rd  <= 32'h0000_0000;
         m1_err <= 1'b0;
         case (stateR)
            IDLE: begin
               if (gntS != 2'b00) begin
                  addrR  <= selAddrS;
                  wdR    <= selWdS;
                  weR    <= selWeS;
                  hitR   <= selHitS;
                  winR   <= gntS[1];
                  cntR   <= CNT_LOAD;
                  pr_we  <= selWeS && selHitS;
                  stateR <= ACCESS;
               end else begin
                  stateR <= IDLE;
               end
            end
            ACCESS: begin
               if (cntR == 4'd0) begin
                  if (winR) begin
                     m1_ack <= 1'b1;
                     m1_rd  <= capRdS;
                     m1_err <= !hitR;
                  end else begin
                     m0_ack <= 1'b1;
                     m0_rd  <= capRdS;
                     m0_err <= !hitR;
                  end
                  stateR <= RESP;
               end else begin
                  cntR   <= cntR - 4'd1;
                  stateR <= ACCESS;
               end
            end
            RESP: begin
               stateR <= IDLE;
            end
            default: begin
               stateR <= IDLE;
            end
         endcase
      end
   end

   assign pr_addr = addrR;
   assign pr_wd   = wdR;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Bench for bridge_arbiter: two instances (round-robin/1 cycle, fixed/4 cycles)
// checked every cycle against a transaction-timeline reference model.
module tb_bridge_arbiter;

   localparam int ACC_A = 1;
   localparam int ACC_B = 4;
   localparam logic [31:0] DBG = 32'hABCD_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        req    [2][2];
   logic [31:0] addr   [2][2];
   logic [31:0] wd     [2][2];
   logic        we     [2][2];
   logic        ack    [2][2];
   logic [31:0] rd     [2][2];
   logic        err    [2][2];
   logic [31:0] prAddr [2];
   logic [31:0] prWd   [2];
   logic        prWe   [2];
   logic [31:0] prRd   [2];

   always #5 clk = ~clk;

   bridge_arbiter #(.RR_EN(1'b1), .ACC_CYC(ACC_A)) dutA (
      .clk(clk), .reset(reset),
      .m0_req(req[0][0]), .m0_addr(addr[0][0]), .m0_wd(wd[0][0]), .m0_we(we[0][0]),
      .m0_ack(ack[0][0]), .m0_rd(rd[0][0]), .m0_err(err[0][0]),
      .m1_req(req[0][1]), .m1_addr(addr[0][1]), .m1_wd(wd[0][1]), .m1_we(we[0][1]),
      .m1_ack(ack[0][1]), .m1_rd(rd[0][1]), .m1_err(err[0][1]),
      .pr_addr(prAddr[0]), .pr_wd(prWd[0]), .pr_we(prWe[0]), .pr_rd(prRd[0]));

   bridge_arbiter #(.RR_EN(1'b0), .ACC_CYC(ACC_B)) dutB (
      .clk(clk), .reset(reset),
      .m0_req(req[1][0]), .m0_addr(addr[1][0]), .m0_wd(wd[1][0]), .m0_we(we[1][0]),
      .m0_ack(ack[1][0]), .m0_rd(rd[1][0]), .m0_err(err[1][0]),
      .m1_req(req[1][1]), .m1_addr(addr[1][1]), .m1_wd(wd[1][1]), .m1_we(we[1][1]),
      .m1_ack(ack[1][1]), .m1_rd(rd[1][1]), .m1_err(err[1][1]),
      .pr_addr(prAddr[1]), .pr_wd(prWd[1]), .pr_we(prWe[1]), .pr_rd(prRd[1]));

   int nChecks = 0;
   int nPass   = 0;
   int nFail   = 0;

   // Reference model: a transaction is a grant edge g; pr_we is seen right
   // after g, the ack right after g+ACC, and the next grant may come at g+ACC+2.
   int          accCyc  [2] = '{ACC_A, ACC_B};
   bit          rrEn    [2] = '{1'b1, 1'b0};
   int          edgeN;
   int          freeAt  [2];
   int          gEdge   [2];
   int          win     [2];
   int          lastWin [2];
   logic [31:0] lAddr   [2];
   logic [31:0] lWd     [2];
   logic        lWe     [2];
   logic        lHit    [2];
   logic [31:0] capRd   [2];

   bit          randMode;
   bit          rdOvr;
   logic [31:0] rdOvrVal;
   int          holdCnt  [2][2];
   int          ackCnt   [2][2];
   int          firstAck [2][2];
   int          lastAck  [2][2];
   logic [31:0] lastRd   [2][2];
   logic        lastErr  [2][2];
   int          weCnt    [2];
   int          rEdge;

   function automatic bit benchHit(input logic [31:0] a);
      return (a >= 32'h7F00 && a <= 32'h7F0B) || (a >= 32'h7F10 && a <= 32'h7F1B);
   endfunction

   function automatic logic [31:0] randAddr();
      case ($urandom_range(0, 3))
         0, 1:    return 32'h7F00 + 32'($urandom_range(0, 31));
         2:       return 32'h7EF0 + 32'($urandom_range(0, 63));
         default: return $urandom;
      endcase
   endfunction

   function automatic bit expAck(input int d, input int m);
      return (edgeN == gEdge[d] + accCyc[d]) && (win[d] == m);
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nChecks++;
      assert (obs === exp) begin
         nPass++;
      end else begin
         nFail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         freeAt[d] = 0;  gEdge[d] = -1000; win[d] = 0; lastWin[d] = 1;
         lAddr[d] = '0;  lWd[d] = '0; lWe[d] = 1'b0; lHit[d] = 1'b0; capRd[d] = '0;
      end
   endtask

   task automatic modelEdge(input int d, input int n);
      int w;
      if (n == gEdge[d] + accCyc[d]) capRd[d] = lWe[d] ? 32'h0 : prRd[d];
      if (n >= freeAt[d] && (req[d][0] || req[d][1])) begin
         if (req[d][0] && req[d][1]) w = (rrEn[d] && lastWin[d] == 0) ? 1 : 0;
         else                        w = req[d][1] ? 1 : 0;
         lAddr[d] = addr[d][w]; lWd[d] = wd[d][w]; lWe[d] = we[d][w];
         lHit[d]  = benchHit(addr[d][w]);
         win[d] = w; lastWin[d] = w; gEdge[d] = n; freeAt[d] = n + accCyc[d] + 2;
      end
   endtask

   task automatic checkDut(input int d);
      bit a;
      check($sformatf("bus d%0d e%0d", d, edgeN),
            128'({prAddr[d], prWd[d], prWe[d]}),
            128'({lAddr[d], lWd[d], (gEdge[d] == edgeN) && lWe[d] && lHit[d]}));
      for (int m = 0; m < 2; m++) begin
         a = expAck(d, m);
         check($sformatf("resp d%0d m%0d e%0d", d, m, edgeN),
               128'({ack[d][m], rd[d][m], err[d][m]}),
               128'({a, a ? capRd[d] : 32'h0, a && !lHit[d]}));
      end
   endtask

   task automatic setTxn(input int d, input int m, input logic [31:0] a,
                         input logic [31:0] w, input logic e);
      req[d][m] = 1'b1; addr[d][m] = a; wd[d][m] = w; we[d][m] = e;
   endtask

   task automatic updateMaster(input int d, input int m);
      if (expAck(d, m)) begin
         if (randMode) begin
            case ($urandom_range(0, 2))
               0:       req[d][m] = req[d][m];
               1:       setTxn(d, m, randAddr(), $urandom, 1'($urandom_range(0, 1)));
               default: req[d][m] = 1'b0;
            endcase
         end else if (holdCnt[d][m] > 0) begin
            holdCnt[d][m]--;
         end else begin
            req[d][m] = 1'b0;
         end
      end else if (randMode) begin
         if (!req[d][m]) begin
            if ($urandom_range(0, 2) == 0) setTxn(d, m, randAddr(), $urandom, 1'($urandom_range(0, 1)));
         end else if (win[d] == m && edgeN >= gEdge[d] && edgeN < gEdge[d] + accCyc[d]
                      && $urandom_range(0, 7) == 0) begin
            req[d][m] = 1'b0;
         end
      end
   endtask

   // One clock: advance the model over the coming edge, then check and restimulate.
   task automatic step();
      edgeN++;
      for (int d = 0; d < 2; d++) modelEdge(d, edgeN);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checkDut(d);
         if (prWe[d]) weCnt[d]++;
         for (int m = 0; m < 2; m++) begin
            if (ack[d][m]) begin
               ackCnt[d][m]++; lastRd[d][m] = rd[d][m]; lastErr[d][m] = err[d][m];
               if (firstAck[d][m] < 0) firstAck[d][m] = edgeN;
               lastAck[d][m] = edgeN;
            end
         end
      end
      for (int d = 0; d < 2; d++)
         for (int m = 0; m < 2; m++) updateMaster(d, m);
      for (int d = 0; d < 2; d++)
         prRd[d] = rdOvr ? rdOvrVal : (benchHit(prAddr[d]) ? $urandom : DBG);
   endtask

   task automatic clearCounters();
      for (int d = 0; d < 2; d++) begin
         weCnt[d] = 0;
         for (int m = 0; m < 2; m++) begin
            ackCnt[d][m] = 0; firstAck[d][m] = -1; lastAck[d][m] = -1;
            lastRd[d][m] = '0; lastErr[d][m] = 1'b0;
         end
      end
   endtask

   task automatic doReset();
      reset = 1'b0;
      #1;
      modelReset();
      for (int d = 0; d < 2; d++) begin
         for (int m = 0; m < 2; m++) begin req[d][m] = 1'b0; holdCnt[d][m] = 0; end
         check($sformatf("rst_out d%0d", d),
               128'({prWe[d], ack[d][0], ack[d][1], prAddr[d], rd[d][0], rd[d][1]}), 128'h0);
         checkDut(d);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; randMode = 1'b0; rdOvr = 1'b1; rdOvrVal = 32'h0000_1234; edgeN = 0;
      for (int d = 0; d < 2; d++) begin
         prRd[d] = 32'h0000_1234;
         for (int m = 0; m < 2; m++) begin
            req[d][m] = 1'b0; addr[d][m] = '0; wd[d][m] = '0; we[d][m] = 1'b0; holdCnt[d][m] = 0;
         end
      end
      modelReset();
      clearCounters();
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) checkDut(d);
      reset = 1'b1;

      // M0 read of DEV0 offset 4
      for (int d = 0; d < 2; d++) setTxn(d, 0, 32'h7F04, 32'h0, 1'b0);
      rEdge = edgeN + 1;
      step();
      check("d1_pr_addr", 128'(prAddr[0]), 128'(32'h7F04));
      step();
      check("d1_ack", 128'({ack[0][0], rd[0][0], err[0][0]}), 128'({1'b1, 32'h1234, 1'b0}));
      repeat (6) step();
      check("d1_b_latency", 128'(firstAck[1][0] - rEdge), 128'(ACC_B));
      check("d1_b_rd", 128'(lastRd[1][0]), 128'(32'h1234));

      // M1 write to DEV1 offset 0: one pr_we pulse regardless of access length
      clearCounters();
      for (int d = 0; d < 2; d++) setTxn(d, 1, 32'h7F10, 32'h9, 1'b1);
      rEdge = edgeN + 1;
      repeat (8) step();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d2_we_pulses d%0d", d), 128'(weCnt[d]), 128'(1));
         check($sformatf("d2_latency d%0d", d), 128'(firstAck[d][1] - rEdge), 128'(accCyc[d]));
         check($sformatf("d2_resp d%0d", d), 128'({ackCnt[d][1], lastRd[d][1], lastErr[d][1]}),
               128'({32'd1, 32'h0, 1'b0}));
      end

      // Both masters requesting continuously
      clearCounters();
      for (int d = 0; d < 2; d++) begin
         setTxn(d, 0, 32'h7F00, 32'h0, 1'b0); setTxn(d, 1, 32'h7F14, 32'h0, 1'b0);
         holdCnt[d][0] = 100; holdCnt[d][1] = 100;
      end
      repeat (12) step();
      check("d3_rr_counts", 128'({ackCnt[0][0], ackCnt[0][1]}), 128'({32'd2, 32'd2}));
      check("d3_rr_first", 128'(firstAck[0][1] - firstAck[0][0]), 128'(3));
      check("d3_fixed_counts", 128'({ackCnt[1][0], ackCnt[1][1]}), 128'({32'd2, 32'd0}));
      for (int d = 0; d < 2; d++) begin holdCnt[d][0] = 0; holdCnt[d][1] = 0; end
      repeat (16) step();

      // Unmapped write and read
      clearCounters();
      rdOvrVal = DBG;
      for (int d = 0; d < 2; d++) setTxn(d, 0, 32'h7F0C, 32'h55, 1'b1);
      repeat (8) step();
      for (int d = 0; d < 2; d++)
         check($sformatf("d4_wr d%0d", d), 128'({weCnt[d], lastErr[d][0], lastRd[d][0]}),
               128'({32'd0, 1'b1, 32'h0}));
      for (int d = 0; d < 2; d++) setTxn(d, 0, 32'h8000, 32'h0, 1'b0);
      repeat (8) step();
      for (int d = 0; d < 2; d++)
         check($sformatf("d4_rd d%0d", d), 128'({ackCnt[d][0], lastErr[d][0], lastRd[d][0]}),
               128'({32'd2, 1'b1, DBG}));

      // Reset in the first ACCESS cycle of a write
      clearCounters();
      rdOvr = 1'b0;
      for (int d = 0; d < 2; d++) setTxn(d, 1, 32'h7F14, 32'h77, 1'b1);
      step();
      check("d5_we_before", 128'({prWe[0], prWe[1]}), 128'(2'b11));
      doReset();
      repeat (8) step();
      check("d5_no_ack", 128'({ackCnt[0][1], ackCnt[1][1]}), 128'h0);

      // M0 holds req through its ack
      clearCounters();
      for (int d = 0; d < 2; d++) begin
         setTxn(d, 0, 32'h7F08, 32'h0, 1'b0); holdCnt[d][0] = 1;
      end
      repeat (16) step();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d6_acks d%0d", d), 128'(ackCnt[d][0]), 128'(2));
         check($sformatf("d6_period d%0d", d), 128'(lastAck[d][0] - firstAck[d][0]),
               128'(accCyc[d] + 2));
      end

      // Randomized traffic with occasional resets
      randMode = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         step();
         if (i % 700 == 699) doReset();
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/bridge_arbiter.md
Name: bridge_arbiter

Overview:
- Shares the Bridge's single processor-side port (PrAddr/PrWD/PrWe/PrRD) between two masters: M0 (CPU MEM stage) and M1 (debug/DMA port).
- Arbitrates, latches the winning request, and sequences one device access with a configurable number of access cycles.
- Returns the read data with a one-cycle ack, and flags accesses outside the DEV0/DEV1 register windows.
- Sits between the masters and the Bridge; the Bridge is unchanged.

Parameters:
- RR_EN, 1: 1 = round-robin arbitration; 0 = fixed priority, M0 wins.
- ACC_CYC, 1: number of ACCESS-state cycles, range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  M0 request; addr/wd/we held stable until m0_ack
- m0_addr  in  32  M0 byte address
- m0_wd  in  32  M0 write data
- m0_we  in  1  M0 write enable (0 = read)
- m0_ack  out  1  one-cycle completion pulse to M0
- m0_rd  out  32  read data, valid while m0_ack = 1
- m0_err  out  1  unmapped address, valid while m0_ack = 1
- m1_req / m1_addr / m1_wd / m1_we / m1_ack / m1_rd / m1_err  (same as M0, for M1)
- pr_addr  out  32  to Bridge PrAddr
- pr_wd  out  32  to Bridge PrWD
- pr_we  out  1  to Bridge PrWe
- pr_rd  in  32  from Bridge PrRD

Behaviour:
- Reset (async, reset = 0):
  - state = IDLE, last-grant pointer = M1 (so M0 wins the first tie).
  - Latches = 0; all outputs = 0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, pick the winner:
    - RR_EN = 1: on a tie, grant the master not granted last.
    - RR_EN = 0: M0 wins.
  - On a grant: latch addr/wd/we and the winner id, compute hit, load the access counter with ACC_CYC-1, update the last-grant pointer, go to ACCESS.
  - Otherwise stay in IDLE.
- hit = 1 when addr is 0x0000_7F00..0x0000_7F0B or 0x0000_7F10..0x0000_7F1B. Offsets 0xC..0xF inside each 16-byte block are not a hit.
- ACCESS:
  - pr_we = latched we AND hit, asserted only in the first ACCESS cycle. A write is issued exactly once, even when ACC_CYC > 1.
  - Counter decrements each cycle. When it reaches 0: capture pr_rd into the rd register (write data 0 is captured for writes, so rd reads 0), go to RESP.
- RESP:
  - Winner's ack = 1 for exactly one cycle, rd = captured value, err = !hit.
  - Loser's ack = 0; its rd/err = 0.
  - Next state is IDLE.
- pr_addr / pr_wd: always driven from the latch registers; they change only on a grant.
- pr_we = 0 in IDLE and RESP.
- Latency: grant-to-ack = ACC_CYC + 1 cycles (req seen in IDLE at cycle t; ack at t+ACC_CYC+1). Minimum period per transaction = ACC_CYC + 2 cycles.
- Request handling:
  - A master still holding req in the cycle after its ack is treated as a new request.
  - A req that drops before ack is ignored once the request is latched; the transaction completes and the ack still pulses.
- Simultaneous requests: a single grant per IDLE cycle. The loser stays pending and is granted on the next IDLE cycle. With RR_EN = 1 neither master starves.
- Unmapped write: no pr_we pulse, err = 1 at ack, rd = captured pr_rd (the Bridge debug constant 0xABCD_FFFF on reads).
- Reset mid-transaction: abort immediately, with no ack pulse after release and pr_we = 0 at once. Masters must reissue.
- rd / err / ack registers are all cleared outside RESP.

Decomposition:
- Shared package `bridge_pkg`:
  - state encoding (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2);
  - DEV0_BASE = 28'h0000_7F0, DEV1_BASE = 28'h0000_7F1, window limit offset 4'hB;
  - DEBUG_DEV_DATA = 32'hABCD_FFFF for benches.
- One sub-module `bridge_rr_arb`: 2-input arbiter holding the last-grant pointer, with inputs req[1:0] and update strobe, and output gnt[1:0]. The FSM, latches and counter stay in the top module.

Test Plan:
- Reset then M0 read 0x7F04, pr_rd = 0x1234, ACC_CYC = 1 → pr_addr = 0x7F04 one cycle after req, m0_ack one cycle later with m0_rd = 0x1234, m0_err = 0.
- M1 write 0x7F10 ← 0x9, ACC_CYC = 3 → pr_we high for exactly one cycle (first ACCESS cycle), m1_ack 4 cycles after req, m1_err = 0.
- Both req high continuously, RR_EN = 1 → grants alternate M0, M1, M0, M1, with acks every 3 cycles; with RR_EN = 0, M0 gets every grant.
- M0 write 0x7F0C and M0 read 0x8000 (pr_rd = 0xABCD_FFFF) → pr_we never asserts; m0_err = 1 both times; the read returns 0xABCD_FFFF.
- Reset asserted during ACCESS of an M1 write with ACC_CYC = 4 → pr_we = 0 immediately, no m1_ack after release, state IDLE, outputs 0.
- M0 holds req through its ack → a second transaction starts in the IDLE cycle after RESP, with exactly two acks total.
